// File: rtl/cj_fuzz_monitor.sv
// Run-completion monitor: drives an LFSR key stream into a small direct-mapped
// tag cache, counts lookups and hits, and raises tohost[0] after NUM_REQ lookups.
module cj_fuzz_monitor #(
  parameter logic [31:0] NUM_REQ   = 32'd1024,
  parameter int          ENTRIES   = 16,
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] tohost,
  output logic [63:0] crednum,
  output logic [63:0] credhit
);

  localparam int          IDX_BITS = $clog2(ENTRIES);
  localparam int          TAG_BITS = ADDR_BITS - IDX_BITS;
  localparam logic [31:0] SEED     = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [63:0] LIMIT    = {32'd0, NUM_REQ};

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         lfsr_q;
  logic [31:0]         lfsr_d;
  logic [63:0]         num_q;
  logic [63:0]         num_d;
  logic [63:0]         hit_cnt_q;
  logic [63:0]         hit_cnt_d;
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];

  logic [ADDR_BITS-1:0] key;
  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 hit;
  logic                 fill;

  assign key = lfsr_q[ADDR_BITS-1:0];
  assign idx = key[IDX_BITS-1:0];
  assign tag = key[ADDR_BITS-1:IDX_BITS];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  // A zero NUM_REQ reaches the limit with no lookup, so RUN checks the limit first.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    num_d     = num_q;
    hit_cnt_d = hit_cnt_q;
    fill      = 1'b0;
    if (state_q == RUN) begin
      if (num_q == LIMIT) begin
        state_d = DONE;
      end else begin
        fill      = !hit;
        num_d     = num_q + 64'd1;
        hit_cnt_d = hit_cnt_q + {63'd0, hit};
        lfsr_d    = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
        if (num_d == LIMIT) begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= RUN;
      lfsr_q    <= SEED;
      num_q     <= 64'd0;
      hit_cnt_q <= 64'd0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      num_q     <= num_d;
      hit_cnt_q <= hit_cnt_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tags need no reset; an entry is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (reset && fill) begin
      tag_q[idx] <= tag;
    end
  end

  assign tohost  = {63'd0, state_q == DONE};
  assign crednum = num_q;
  assign credhit = hit_cnt_q;

endmodule

// File: tb/tb_cj_fuzz_monitor.sv
// Scoreboard bench for cj_fuzz_monitor: four instances with different NUM_REQ
// share one clock and reset and are checked every cycle against a cache model.
module tb_cj_fuzz_monitor;

  localparam int          N_DUT = 4;
  localparam logic [31:0] REQ [N_DUT] = '{32'd5, 32'd3, 32'd0, 32'd1024};
  localparam logic [63:0] DONE_HIT [N_DUT] = '{64'd2, 64'd0, 64'd0, 64'd0};

  typedef struct packed {
    logic [63:0] tohost;
    logic [63:0] crednum;
    logic [63:0] credhit;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] tohost_w  [N_DUT];
  logic [63:0] crednum_w [N_DUT];
  logic [63:0] credhit_w [N_DUT];

  exp_t exp_q[$];
  exp_t e_mon;
  bit   stim_active = 1'b1;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;
  int edges_since  = 0;
  bit prev_done [N_DUT];

  logic [31:0]     m_lfsr  [N_DUT];
  longint unsigned m_num   [N_DUT];
  longint unsigned m_hit   [N_DUT];
  bit              m_done  [N_DUT];
  bit              m_valid [N_DUT][16];
  int unsigned     m_tag   [N_DUT][16];

  always #5 clock = ~clock;

  cj_fuzz_monitor #(.NUM_REQ(32'd5)) dut_5 (
    .clock(clock), .reset(reset),
    .tohost(tohost_w[0]), .crednum(crednum_w[0]), .credhit(credhit_w[0]));
  cj_fuzz_monitor #(.NUM_REQ(32'd3)) dut_3 (
    .clock(clock), .reset(reset),
    .tohost(tohost_w[1]), .crednum(crednum_w[1]), .credhit(credhit_w[1]));
  cj_fuzz_monitor #(.NUM_REQ(32'd0)) dut_0 (
    .clock(clock), .reset(reset),
    .tohost(tohost_w[2]), .crednum(crednum_w[2]), .credhit(credhit_w[2]));
  cj_fuzz_monitor #(.NUM_REQ(32'd1024)) dut_1024 (
    .clock(clock), .reset(reset),
    .tohost(tohost_w[3]), .crednum(crednum_w[3]), .credhit(credhit_w[3]));

  // Reference: key is the low 10 bits of the LFSR, 16 sets, tag is the rest.
  task automatic model_edge(input logic rst_n);
    int unsigned key;
    int unsigned set;
    int unsigned t;
    for (int i = 0; i < N_DUT; i++) begin
      if (!rst_n) begin
        m_lfsr[i] = 32'd1;
        m_num[i]  = 0;
        m_hit[i]  = 0;
        m_done[i] = 1'b0;
        for (int j = 0; j < 16; j++) m_valid[i][j] = 1'b0;
      end else if (!m_done[i]) begin
        if (m_num[i] == longint'(REQ[i])) begin
          m_done[i] = 1'b1;
        end else begin
          key = m_lfsr[i] % 1024;
          set = key % 16;
          t   = key / 16;
          if (m_valid[i][set] && m_tag[i][set] == t) begin
            m_hit[i]++;
          end else begin
            m_valid[i][set] = 1'b1;
            m_tag[i][set]   = t;
          end
          m_num[i]++;
          if (m_lfsr[i] % 2 == 1) m_lfsr[i] = (m_lfsr[i] >> 1) ^ 32'h8020_0003;
          else                    m_lfsr[i] = m_lfsr[i] >> 1;
          if (m_num[i] == longint'(REQ[i])) m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic apply_stimulus(input logic rst_n, input int cycles);
    exp_t e;
    repeat (cycles) begin
      reset = rst_n;
      model_edge(rst_n);
      for (int i = 0; i < N_DUT; i++) begin
        e.tohost  = {63'd0, m_done[i]};
        e.crednum = m_num[i];
        e.credhit = m_hit[i];
        exp_q.push_back(e);
      end
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h",
               name, idx, cycle, got, exp);
    end
  endtask

  // Monitor: one scoreboard entry per instance per edge, plus completion checks.
  always begin
    @(posedge clock);
    #1;
    cycle++;
    if (reset == 1'b0) edges_since = 0;
    else               edges_since++;
    if (exp_q.size() >= N_DUT) begin
      for (int i = 0; i < N_DUT; i++) begin
        e_mon = exp_q.pop_front();
        check_output("tohost",  i, tohost_w[i],  e_mon.tohost);
        check_output("crednum", i, crednum_w[i], e_mon.crednum);
        check_output("credhit", i, credhit_w[i], e_mon.credhit);
        check_output("invariant", i, {63'd0, credhit_w[i] <= crednum_w[i]}, 64'd1);
        if (tohost_w[i][0] === 1'b1 && !prev_done[i]) begin
          check_output("done_edge", i, 64'(edges_since),
                       (REQ[i] == 32'd0) ? 64'd1 : {32'd0, REQ[i]});
          check_output("done_num", i, crednum_w[i], {32'd0, REQ[i]});
          if (i < 3) check_output("done_hit", i, credhit_w[i], DONE_HIT[i]);
        end
        prev_done[i] = (tohost_w[i][0] === 1'b1);
      end
    end else if (stim_active) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_underflow cycle %0d: got %0d entries, expected %0d",
               cycle, exp_q.size(), N_DUT);
    end
  end

  initial begin
    for (int i = 0; i < N_DUT; i++) prev_done[i] = 1'b0;
    $display("[TB] start");
    apply_stimulus(1'b0, int'($urandom_range(2, 5)));
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b1, 498);
    apply_stimulus(1'b0, 1);
    apply_stimulus(1'b1, 1100);
    apply_stimulus(1'b0, int'($urandom_range(1, 3)));
    apply_stimulus(1'b1, int'($urandom_range(10, 1000)));
    apply_stimulus(1'b0, 1);
    apply_stimulus(1'b1, 1100);
    stim_active = 1'b0;
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
